// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory stage (master) and the data
// memory responder (slave): two independent valid/ready handshakes.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Big-endian byte-addressed data memory behind a one-outstanding request/response
// handshake with programmable access latency. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  data_mem_responder_if.slave        bus
);
  localparam int          NBYTES   = 4 * DEPTH_WORDS;
  localparam int          AW       = $clog2(NBYTES);
  localparam logic [31:0] LIMIT    = 32'(NBYTES);
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Storage powers up zeroed and deliberately survives reset.
  logic [7:0]  mem_q [NBYTES] = '{default: 8'h00};

  logic          access;
  logic          align_err;
  logic          acc_err;
  logic          wr_en;
  logic [AW-3:0] word_idx;
  logic [31:0]   rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
        else               state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (state_q == ST_IDLE && bus.req_valid) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      wstrb_d = bus.req_wstrb;
    end
  end

  // Access happens on the edge that leaves WAIT with an expired counter.
  always_comb begin
    access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    align_err = (addr_q[1:0] != 2'b00);
`else
    align_err = 1'b0;
`endif
    acc_err  = (addr_q >= LIMIT) || align_err;
    word_idx = addr_q[AW-1:2];
    rd_word  = {mem_q[{word_idx, 2'd0}], mem_q[{word_idx, 2'd1}],
                mem_q[{word_idx, 2'd2}], mem_q[{word_idx, 2'd3}]};
    wr_en    = access && write_q && !acc_err;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (access) begin
      err_d   = acc_err;
      rdata_d = (write_q || acc_err) ? 32'h0 : rd_word;
    end
  end

  // Strobe bit 3 maps to the lowest byte address (big-endian lane order).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[3-i]) mem_q[{word_idx, 2'(i)}] <= wdata_q[31-8*i -: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder: a cycle-level reference
// model checked every cycle, plus directed literal checks from the test plan.
module tb_data_mem_responder;
  localparam int DEPTH = 512;
  localparam int LAT   = 2;
  localparam int NB    = 4 * DEPTH;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: byte array plus "accepted at cycle N, answered at N+LAT+1".
  logic [7:0]  mdl_mem [NB];
  int          phase   = 0; // 0 idle, 1 request pending, 2 response presented
  int          cyc     = 0;
  int          acc_cyc = 0;
  logic        m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_err;

  initial foreach (mdl_mem[i]) mdl_mem[i] = 8'h00;

  function automatic void model_access();
    int base;
    m_err   = (m_addr >= 32'(NB)) || (ALIGN && m_addr[1:0] != 2'b00);
    m_rdata = 32'h0;
    if (!m_err) begin
      base = int'(m_addr & 32'hFFFF_FFFC);
      if (m_write) begin
        for (int i = 0; i < 4; i++)
          if (m_wstrb[3-i]) mdl_mem[base+i] = m_wdata[31-8*i -: 8];
      end else begin
        m_rdata = {mdl_mem[base], mdl_mem[base+1], mdl_mem[base+2], mdl_mem[base+3]};
      end
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (phase == 2) begin
        if (bus.resp_ready) phase = 0;
      end else if (phase == 1) begin
        if (cyc == acc_cyc + LAT + 1) begin
          model_access();
          phase = 2;
        end
      end else if (bus.req_valid) begin
        m_write = bus.req_write;
        m_addr  = bus.req_addr;
        m_wdata = bus.req_wdata;
        m_wstrb = bus.req_wstrb;
        acc_cyc = cyc;
        phase   = 1;
      end
    end
  end

  always @(negedge rst_n) phase = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready",  32'(bus.req_ready),  32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata,      32'h0);
      check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    end else begin
      check("cyc_req_ready",  32'(bus.req_ready),  32'(phase == 0));
      check("cyc_resp_valid", 32'(bus.resp_valid), 32'(phase == 2));
      if (phase == 2) begin
        check("cyc_resp_rdata", bus.resp_rdata,    m_rdata);
        check("cyc_resp_err",   32'(bus.resp_err), 32'(m_err));
      end
    end
  end

  logic [31:0] rd;
  logic        re;

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int hold,
                     output logic [31:0] rdata, output logic err);
    int t;
    bit ok;
    rdata = 32'h0;
    err   = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      else t++;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", t);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    t = 0;
    while (!bus.resp_valid && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    check("resp_latency", 32'(t), 32'(LAT + 1));
    if (!bus.resp_valid) return;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check("ready_after_hs", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_wstrb  = 4'h0;
    bus.resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    txn(1'b1, 32'h34, 32'hDEADBEEF, 4'hF, 0, rd, re);
    check("st34_err", 32'(re), 32'd0);
    check("st34_rdata", rd, 32'h0);
    txn(1'b0, 32'h34, 32'h0, 4'h0, 0, rd, re);
    check("ld34_rdata", rd, 32'hDEADBEEF);
    check("ld34_err", 32'(re), 32'd0);

    txn(1'b1, 32'h40, 32'h11223344, 4'hF, 0, rd, re);
    txn(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1, rd, re);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, re);
    check("ld40_merge", rd, 32'h11BB33DD);

    txn(1'b0, 32'h800, 32'h0, 4'h0, 0, rd, re);
    check("ld800_err", 32'(re), 32'd1);
    check("ld800_rdata", rd, 32'h0);
    txn(1'b1, 32'h800, 32'hCAFEF00D, 4'hF, 0, rd, re);
    check("st800_err", 32'(re), 32'd1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, re);
    check("ld0_rdata", rd, 32'h0);
    check("ld0_err", 32'(re), 32'd0);

    txn(1'b0, 32'h42, 32'h0, 4'h0, 0, rd, re);
`ifdef DMEM_ALIGN_CHECK_EN
    check("ld42_err", 32'(re), 32'd1);
    check("ld42_rdata", rd, 32'h0);
`else
    check("ld42_err", 32'(re), 32'd0);
    check("ld42_rdata", rd, 32'h11BB33DD);
`endif

    txn(1'b0, 32'h34, 32'h0, 4'h0, 10, rd, re);
    check("ld34_held", rd, 32'hDEADBEEF);

    // Reset while a store to 0x50 is still waiting for its access.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h50;
    bus.req_wdata = 32'h55AA55AA;
    bus.req_wstrb = 4'hF;
    @(negedge clk);
    check("rst_test_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b0, 32'h50, 32'h0, 4'h0, 0, rd, re);
    check("ld50_after_rst", rd, 32'h0);
    check("ld50_err", 32'(re), 32'd0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h800 + $urandom_range(0, 255);
        1:       a = $urandom | 32'h8000_0000;
        2:       a = $urandom_range(0, NB - 1);
        default: a = 32'h300 + $urandom_range(0, 63);
      endcase
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), rd, re);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
